// File: rtl/int_arb.sv
// int_arb: interrupt arbiter between the SoC peripherals and the tinyriscv core.
// NUM_CH maskable channels, each edge or level triggered. Pending channels are
// arbitrated and presented one at a time as an encoded ID with a valid/ack
// handshake. Further requests are held off until end-of-interrupt.
// Build option: define INT_ARB_RR_EN for round-robin arbitration. Without it,
// arbitration is fixed priority and the lowest channel index wins.
module int_arb #(
    parameter int NUM_CH = 8,
    parameter int INT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] irq_i,
    input  logic [NUM_CH-1:0] mode_i,
    input  logic [NUM_CH-1:0] mask_i,
    input  logic              ack_i,
    input  logic              eoi_i,
    output logic [INT_W-1:0]  int_o,
    output logic              int_valid_o,
    output logic              busy_o,
    output logic [NUM_CH-1:0] pending_o
);

    localparam int GNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [NUM_CH-1:0] s1;
    logic [NUM_CH-1:0] s2;
    logic [NUM_CH-1:0] s3;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] pend_d;
    logic [NUM_CH-1:0] cand;

    logic [GNT_W-1:0]  grant;
    logic [GNT_W-1:0]  grant_d;
    logic [GNT_W-1:0]  winner;
    logic              found;

    logic [INT_W-1:0]  int_d;
    logic              valid_d;
    logic              busy_d;
    logic              ack_take;
    logic              svc_hold;

    assign rise      = s2 & ~s3;
    assign cand      = pending & mask_i;
    assign pending_o = pending;

    // Two-flop synchroniser on the raw requests, plus a delayed copy for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= irq_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // The in-service level channel is frozen until eoi, so it cannot re-request itself.
    assign svc_hold = (state_q == SVC) && !eoi_i;

    // Next pending: an edge sets and an ack clears (set wins); level follows the line.
    always_comb begin
        pend_d = pending;
        for (int c = 0; c < NUM_CH; c++) begin
            if (mode_i[c]) begin
                pend_d[c] = rise[c] | (pending[c] & !(ack_take && (int'(grant) == c)));
            end else if (svc_hold && (int'(grant) == c)) begin
                pend_d[c] = pending[c];
            end else begin
                pend_d[c] = s2[c];
            end
        end
    end

    // Pending register; masked channels still latch here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pend_d;
        end
    end

`ifdef INT_ARB_RR_EN
    logic [GNT_W-1:0] rr_ptr;
    logic [GNT_W-1:0] sel;
    int               idx;

    // Round-robin search that starts at the channel after the last one granted.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        sel    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_CH;
            sel = idx[GNT_W-1:0];
            if (!found && cand[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

    // Pointer advances past the granted channel when the core takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (ack_take) begin
            rr_ptr <= (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
        end
    end
`else
    // Fixed priority: the lowest candidate index wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (cand[c]) begin
                found  = 1'b1;
                winner = GNT_W'(c);
            end
        end
    end
`endif

    // Handshake FSM: next state and registered-output values.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant;
        int_d    = int_o;
        valid_d  = int_valid_o;
        busy_d   = busy_o;
        ack_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = winner;
                    int_d   = INT_W'(winner) + INT_W'(1);
                    valid_d = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_i) begin
                    ack_take = 1'b1;
                    valid_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = SVC;
                end else if (!cand[grant]) begin
                    // Masked or line dropped before the core took it: withdraw.
                    valid_d = 1'b0;
                    int_d   = '0;
                    state_d = IDLE;
                end
            end
            SVC: begin
                if (eoi_i) begin
                    busy_d  = 1'b0;
                    int_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                int_d   = '0;
            end
        endcase
    end

    // FSM state, grant and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant       <= '0;
            int_o       <= '0;
            int_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant       <= grant_d;
            int_o       <= int_d;
            int_valid_o <= valid_d;
            busy_o      <= busy_d;
        end
    end

endmodule
